// File: rtl/axi4_lite_master_if.sv
// Local RAM-style request port to AXI4-Lite master bridge, one transaction in flight.
// Optional macro AXI4_LITE_MASTER_ERR_CNT_EN adds a saturating error-response counter (err_cnt).
module axi4_lite_master_if #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int REG_ADDR_BIT       = 8,
    parameter int C_M_AXI_ADDR_WIDTH = REG_ADDR_BIT + $clog2(C_M_AXI_DATA_WIDTH/8)
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,
    input  logic [REG_ADDR_BIT-1:0]         local_waddr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   local_wdata,
    input  logic                            local_wen,
    input  logic [REG_ADDR_BIT-1:0]         local_raddr,
    input  logic                            local_ren,
    output logic                            local_ready,
    output logic                            local_wdone,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   local_rdata,
    output logic                            local_rdatavalid,
    output logic [1:0]                      local_resp
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
    ,
    output logic [15:0]                     err_cnt
`endif
);

    localparam int LSB = $clog2(C_M_AXI_DATA_WIDTH/8);

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD, RD_R} state_t;

    state_t                          state, state_nxt;
    logic                            pend_rd, pend_rd_nxt;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_nxt, araddr_nxt;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_nxt, rdata_nxt;
    logic                            awvalid_nxt, wvalid_nxt, bready_nxt;
    logic                            arvalid_nxt, rready_nxt;
    logic                            wdone_nxt, rdv_nxt;
    logic [1:0]                      resp_nxt;

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;
    assign local_ready  = (state == IDLE);

    always_comb begin
        state_nxt   = state;
        pend_rd_nxt = pend_rd;
        awaddr_nxt  = M_AXI_AWADDR;
        araddr_nxt  = M_AXI_ARADDR;
        wdata_nxt   = M_AXI_WDATA;
        rdata_nxt   = local_rdata;
        awvalid_nxt = M_AXI_AWVALID;
        wvalid_nxt  = M_AXI_WVALID;
        bready_nxt  = M_AXI_BREADY;
        arvalid_nxt = M_AXI_ARVALID;
        rready_nxt  = M_AXI_RREADY;
        wdone_nxt   = 1'b0;
        rdv_nxt     = 1'b0;
        resp_nxt    = local_resp;
        case (state)
            IDLE: begin
                // A read arriving with a write is parked in ARADDR and issued after B.
                if (local_ren)
                    araddr_nxt = C_M_AXI_ADDR_WIDTH'({local_raddr, {LSB{1'b0}}});
                if (local_wen) begin
                    awaddr_nxt  = C_M_AXI_ADDR_WIDTH'({local_waddr, {LSB{1'b0}}});
                    wdata_nxt   = local_wdata;
                    awvalid_nxt = 1'b1;
                    wvalid_nxt  = 1'b1;
                    pend_rd_nxt = local_ren;
                    state_nxt   = WR;
                end else if (local_ren) begin
                    arvalid_nxt = 1'b1;
                    state_nxt   = RD;
                end
            end
            WR: begin
                awvalid_nxt = M_AXI_AWVALID & ~M_AXI_AWREADY;
                wvalid_nxt  = M_AXI_WVALID & ~M_AXI_WREADY;
                if (!awvalid_nxt && !wvalid_nxt) begin
                    bready_nxt = 1'b1;
                    state_nxt  = WR_B;
                end
            end
            WR_B: begin
                if (M_AXI_BVALID && M_AXI_BREADY) begin
                    bready_nxt = 1'b0;
                    wdone_nxt  = 1'b1;
                    resp_nxt   = M_AXI_BRESP;
                    if (pend_rd) begin
                        pend_rd_nxt = 1'b0;
                        arvalid_nxt = 1'b1;
                        state_nxt   = RD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            RD: begin
                if (M_AXI_ARREADY) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = RD_R;
                end
            end
            RD_R: begin
                if (M_AXI_RVALID && M_AXI_RREADY) begin
                    rready_nxt = 1'b0;
                    rdata_nxt  = M_AXI_RDATA;
                    resp_nxt   = M_AXI_RRESP;
                    rdv_nxt    = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state            <= IDLE;
            pend_rd          <= 1'b0;
            M_AXI_AWADDR     <= '0;
            M_AXI_ARADDR     <= '0;
            M_AXI_WDATA      <= '0;
            M_AXI_AWVALID    <= 1'b0;
            M_AXI_WVALID     <= 1'b0;
            M_AXI_BREADY     <= 1'b0;
            M_AXI_ARVALID    <= 1'b0;
            M_AXI_RREADY     <= 1'b0;
            local_wdone      <= 1'b0;
            local_rdatavalid <= 1'b0;
            local_rdata      <= '0;
            local_resp       <= 2'b00;
        end else begin
            state            <= state_nxt;
            pend_rd          <= pend_rd_nxt;
            M_AXI_AWADDR     <= awaddr_nxt;
            M_AXI_ARADDR     <= araddr_nxt;
            M_AXI_WDATA      <= wdata_nxt;
            M_AXI_AWVALID    <= awvalid_nxt;
            M_AXI_WVALID     <= wvalid_nxt;
            M_AXI_BREADY     <= bready_nxt;
            M_AXI_ARVALID    <= arvalid_nxt;
            M_AXI_RREADY     <= rready_nxt;
            local_wdone      <= wdone_nxt;
            local_rdatavalid <= rdv_nxt;
            local_rdata      <= rdata_nxt;
            local_resp       <= resp_nxt;
        end
    end

`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
    logic err_inc;
    assign err_inc = (state == WR_B && M_AXI_BVALID && M_AXI_BREADY && M_AXI_BRESP != 2'b00) ||
                     (state == RD_R && M_AXI_RVALID && M_AXI_RREADY && M_AXI_RRESP != 2'b00);

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET)
            err_cnt <= 16'h0000;
        else if (err_inc && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'h0001;
    end
`endif

endmodule

// File: tb/tb_axi4_lite_master_if.sv
// Directed bench for axi4_lite_master_if: configurable-delay AXI4-Lite slave model plus
// a completion scoreboard; optional err_cnt checks follow AXI4_LITE_MASTER_ERR_CNT_EN.
module tb_axi4_lite_master_if;

    localparam int DW = 32;
    localparam int AB = 8;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic [AB-1:0] local_waddr, local_raddr;
    logic [DW-1:0] local_wdata, local_rdata;
    logic          local_wen, local_ren, local_ready, local_wdone, local_rdatavalid;
    logic [1:0]    local_resp;
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
    logic [15:0]   err_cnt;
`endif

    always #5 clk = ~clk;

    axi4_lite_master_if #(.C_M_AXI_DATA_WIDTH(DW), .REG_ADDR_BIT(AB)) dut (
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
        .err_cnt(err_cnt),
`endif
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .local_waddr(local_waddr), .local_wdata(local_wdata), .local_wen(local_wen),
        .local_raddr(local_raddr), .local_ren(local_ren), .local_ready(local_ready),
        .local_wdone(local_wdone), .local_rdata(local_rdata),
        .local_rdatavalid(local_rdatavalid), .local_resp(local_resp)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int            aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]    bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    int            aw_wait, w_wait, ar_wait, r_wait;
    logic          got_aw, got_w, r_pend;
    logic [AW-1:0] cap_awaddr, r_addr;
    logic [DW-1:0] cap_wdata;
    logic [3:0]    cap_wstrb;
    logic [DW-1:0] mem [256];
    logic [AW-1:0] cur_awaddr;
    logic [DW-1:0] cur_wdata;
    logic          aw_hs, w_hs;

    assign awready    = awvalid && (aw_wait >= aw_delay);
    assign wready     = wvalid && (w_wait >= w_delay);
    assign arready    = arvalid && (ar_wait >= ar_delay);
    assign aw_hs      = awvalid && awready;
    assign w_hs       = wvalid && wready;
    assign cur_awaddr = aw_hs ? awaddr : cap_awaddr;
    assign cur_wdata  = w_hs ? wdata : cap_wdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; r_wait <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; r_pend <= 1'b0;
            bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
            cap_awaddr <= '0; cap_wdata <= '0; cap_wstrb <= '0; r_addr <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
            if (aw_hs) begin got_aw <= 1'b1; cap_awaddr <= awaddr; end
            if (w_hs) begin got_w <= 1'b1; cap_wdata <= wdata; cap_wstrb <= wstrb; end
            if ((got_aw || aw_hs) && (got_w || w_hs) && !bvalid) begin
                mem[cur_awaddr[AW-1:2]] <= cur_wdata;
                bvalid <= 1'b1; bresp <= bresp_cfg;
                got_aw <= 1'b0; got_w <= 1'b0;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin
                if (r_delay == 0) begin
                    rvalid <= 1'b1; rdata <= mem[araddr[AW-1:2]]; rresp <= rresp_cfg;
                end else begin
                    r_pend <= 1'b1; r_wait <= 1; r_addr <= araddr;
                end
            end
            if (r_pend) begin
                if (r_wait >= r_delay) begin
                    rvalid <= 1'b1; rdata <= mem[r_addr[AW-1:2]]; rresp <= rresp_cfg; r_pend <= 1'b0;
                end else begin
                    r_wait <= r_wait + 1;
                end
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    typedef struct {
        bit         is_rd;
        logic [31:0] data;
        logic [1:0]  resp;
        int          t_req;
        bit          lat_chk;
    } exp_t;
    exp_t sb[$];

    int cyc = 0;
    int wdone_cnt = 0, rdv_cnt = 0, b_hs = 0, ar_hs = 0;
    int ar_hi = 0, aw_only = 0, w_only = 0, viol = 0;
    logic p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
    logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
    logic [DW-1:0] p_wdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
        end else begin
            if (arvalid) ar_hi <= ar_hi + 1;
            if (awvalid && !wvalid) aw_only <= aw_only + 1;
            if (wvalid && !awvalid) w_only <= w_only + 1;
            if (bvalid && bready) b_hs <= b_hs + 1;
            if (arvalid && arready) ar_hs <= ar_hs + 1;
            viol <= viol + ((p_aw && (!awvalid || awaddr !== p_awaddr)) ? 1 : 0)
                         + ((p_w && (!wvalid || wdata !== p_wdata)) ? 1 : 0)
                         + ((p_ar && (!arvalid || araddr !== p_araddr)) ? 1 : 0);
            p_aw <= awvalid && !awready; p_awaddr <= awaddr;
            p_w  <= wvalid && !wready;   p_wdata  <= wdata;
            p_ar <= arvalid && !arready; p_araddr <= araddr;
            if (local_wdone) begin
                wdone_cnt <= wdone_cnt + 1;
                check("wdone_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    check("wdone_order", sb[0].is_rd, 0);
                    check("wdone_resp", local_resp, sb[0].resp);
                    if (sb[0].lat_chk) check("wdone_latency", cyc - sb[0].t_req, 3);
                    sb.delete(0);
                end
            end
            if (local_rdatavalid) begin
                rdv_cnt <= rdv_cnt + 1;
                check("rdv_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    check("rdv_order", sb[0].is_rd, 1);
                    check("rdv_data", local_rdata, sb[0].data);
                    check("rdv_resp", local_resp, sb[0].resp);
                    if (sb[0].lat_chk) check("rdv_latency", cyc - sb[0].t_req, 3);
                    sb.delete(0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_write(input logic [7:0] a, input logic [31:0] d, input bit lat);
        @(negedge clk);
        local_waddr = a; local_wdata = d; local_wen = 1'b1;
        sb.push_back('{is_rd: 1'b0, data: 32'h0, resp: bresp_cfg, t_req: cyc, lat_chk: lat});
        @(negedge clk);
        local_wen = 1'b0;
    endtask

    task automatic drive_read(input logic [7:0] a, input logic [31:0] d, input logic [1:0] r, input bit lat);
        @(negedge clk);
        local_raddr = a; local_ren = 1'b1;
        sb.push_back('{is_rd: 1'b1, data: d, resp: r, t_req: cyc, lat_chk: lat});
        @(negedge clk);
        local_ren = 1'b0;
    endtask

    task automatic wait_done(input bit rd, input int target, input string tag);
        int n = 0;
        while ((rd ? rdv_cnt : wdone_cnt) < target && n < 100) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_completed"}, (rd ? rdv_cnt : wdone_cnt) >= target, 1);
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int tgt, base_a, base_b, base_c, base_d, glitch, seen;
        local_waddr = '0; local_wdata = '0; local_wen = 1'b0;
        local_raddr = '0; local_ren = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_ready", local_ready, 1);
        check("rst_wdone", local_wdone, 0);
        check("rst_rdv", local_rdatavalid, 0);
        check("rst_rdata", local_rdata, 0);
        check("rst_resp", local_resp, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_wdata", wdata, 0);
        rst = 1'b0;

        // zero-wait write, then zero-wait read of the same word
        tgt = wdone_cnt + 1;
        drive_write(8'h05, 32'hDEADBEEF, 1);
        wait_done(0, tgt, "t1_write");
        check("t1_awaddr", cap_awaddr, 10'h014);
        check("t1_wstrb", cap_wstrb, 4'hF);
        check("t1_awprot", awprot, 0);
        check("t1_arprot", arprot, 0);
        tgt = rdv_cnt + 1;
        drive_read(8'h05, 32'hDEADBEEF, 2'b00, 1);
        wait_done(1, tgt, "t2_read");

        // ARREADY held off for 4 cycles
        ar_delay = 4;
        base_a = ar_hi; base_b = rdv_cnt;
        drive_read(8'h05, 32'hDEADBEEF, 2'b00, 0);
        wait_done(1, base_b + 1, "t3_read");
        check("t3_arvalid_cycles", ar_hi - base_a, 5);
        check("t3_rdv_pulses", rdv_cnt - base_b, 1);
        check("t3_stable", viol, 0);
        ar_delay = 0;

        // WREADY before AWREADY; a read strobe while busy must be ignored
        aw_delay = 2;
        base_a = aw_only; base_b = w_only; base_c = b_hs; base_d = ar_hs; tgt = wdone_cnt + 1;
        drive_write(8'h20, 32'h12345678, 0);
        check("t4_busy", local_ready, 0);
        local_raddr = 8'h03; local_ren = 1'b1;
        @(negedge clk);
        local_ren = 1'b0;
        wait_done(0, tgt, "t4a_write");
        check("t4a_aw_only", aw_only - base_a, 2);
        check("t4a_w_only", w_only - base_b, 0);
        check("t4a_b_hs", b_hs - base_c, 1);
        check("t4a_wdone", wdone_cnt - (tgt - 1), 1);
        aw_delay = 0; w_delay = 2;
        base_a = aw_only; base_b = w_only; base_c = b_hs; tgt = wdone_cnt + 1;
        drive_write(8'h21, 32'h9ABCDEF0, 0);
        wait_done(0, tgt, "t4b_write");
        check("t4b_w_only", w_only - base_b, 2);
        check("t4b_aw_only", aw_only - base_a, 0);
        check("t4b_b_hs", b_hs - base_c, 1);
        check("t4_ignored_ren", ar_hs - base_d, 0);
        w_delay = 0;
        tgt = rdv_cnt + 1;
        drive_read(8'h20, 32'h12345678, 2'b00, 1);
        wait_done(1, tgt, "t4_readback");

        // simultaneous write and read of the same word
        tgt = rdv_cnt + 1;
        @(negedge clk);
        local_waddr = 8'h0A; local_wdata = 32'h11; local_raddr = 8'h0A;
        local_wen = 1'b1; local_ren = 1'b1;
        sb.push_back('{is_rd: 1'b0, data: 32'h0, resp: 2'b00, t_req: cyc, lat_chk: 1'b1});
        sb.push_back('{is_rd: 1'b1, data: 32'h11, resp: 2'b00, t_req: cyc, lat_chk: 1'b0});
        @(negedge clk);
        local_wen = 1'b0; local_ren = 1'b0;
        glitch = 0; seen = 0;
        for (int n = 0; n < 40 && seen == 0; n++) begin
            if (local_rdatavalid) seen = 1;
            else if (local_ready) glitch++;
            if (seen == 0) @(negedge clk);
        end
        check("t5_rdv_seen", seen, 1);
        check("t5_ready_low", glitch, 0);
        wait_done(1, tgt, "t5_read");

        // error response on read
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
        check("t6_errcnt_before", err_cnt, 0);
`endif
        rresp_cfg = 2'b10;
        tgt = rdv_cnt + 1;
        drive_read(8'h0A, 32'h11, 2'b10, 0);
        wait_done(1, tgt, "t6_read");
        check("t6_resp_held", local_resp, 2'b10);
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
        check("t6_errcnt_after", err_cnt, 1);
`endif
        rresp_cfg = 2'b00;

        // reset while waiting for R
        r_delay = 10;
        drive_read(8'h05, 32'h0, 2'b00, 0);
        seen = 0;
        for (int n = 0; n < 40 && seen == 0; n++) begin
            @(negedge clk);
            if (rready) seen = 1;
        end
        check("t7_in_rd_r", seen, 1);
        rst = 1'b1;
        #1;
        check("t7_rready", rready, 0);
        check("t7_arvalid", arvalid, 0);
        check("t7_bready", bready, 0);
        check("t7_ready", local_ready, 1);
        check("t7_rdata", local_rdata, 0);
        check("t7_resp", local_resp, 0);
`ifdef AXI4_LITE_MASTER_ERR_CNT_EN
        check("t7_errcnt", err_cnt, 0);
`endif
        sb.delete();
        base_a = rdv_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        r_delay = 0;
        repeat (5) @(posedge clk);
        check("t7_no_rdv", rdv_cnt - base_a, 0);
        tgt = wdone_cnt + 1;
        drive_write(8'h33, 32'hCAFEF00D, 1);
        wait_done(0, tgt, "t7_write");
        check("t7_awaddr", cap_awaddr, 10'h0CC);
        tgt = rdv_cnt + 1;
        drive_read(8'h33, 32'hCAFEF00D, 2'b00, 1);
        wait_done(1, tgt, "t7_read");

        repeat (2) @(posedge clk);
        check("end_protocol", viol, 0);
        check("end_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master_if.md
Name: axi4_lite_master_if

Overview:
RAM-style local request port to AXI4-Lite master bridge; the initiator counterpart of the team's AXI4-Lite slave register interface. Lets local control logic (e.g. a config sequencer or a test driver) read and write any AXI4-Lite register block using word addresses and single-cycle strobes. One outstanding transaction at a time; registered AXI outputs; no data storage beyond one pending request.

Parameters:
C_M_AXI_DATA_WIDTH, 32, AXI data width (32 or 64)
REG_ADDR_BIT, 8, local word-address width
C_M_AXI_ADDR_WIDTH, REG_ADDR_BIT + $clog2(C_M_AXI_DATA_WIDTH/8), AXI byte-address width

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESET  in  1  asynchronous, active-high reset
M_AXI_AWADDR/AWPROT/AWVALID  out  C_M_AXI_ADDR_WIDTH/3/1  write-address channel
M_AXI_AWREADY  in  1
M_AXI_WDATA/WSTRB/WVALID  out  C_M_AXI_DATA_WIDTH/C_M_AXI_DATA_WIDTH/8/1  write-data channel
M_AXI_WREADY  in  1
M_AXI_BRESP/BVALID  in  2/1;  M_AXI_BREADY  out  1
M_AXI_ARADDR/ARPROT/ARVALID  out  C_M_AXI_ADDR_WIDTH/3/1;  M_AXI_ARREADY  in  1
M_AXI_RDATA/RRESP/RVALID  in  C_M_AXI_DATA_WIDTH/2/1;  M_AXI_RREADY  out  1
local_waddr  in  REG_ADDR_BIT  write word address
local_wdata  in  C_M_AXI_DATA_WIDTH  write data
local_wen  in  1  write request strobe, sampled only when local_ready=1
local_raddr  in  REG_ADDR_BIT  read word address
local_ren  in  1  read request strobe, sampled only when local_ready=1
local_ready  out  1  idle and accepting requests
local_wdone  out  1  one-cycle pulse: write response received
local_rdata  out  C_M_AXI_DATA_WIDTH  read data, held until next read completes
local_rdatavalid  out  1  one-cycle pulse: local_rdata updated
local_resp  out  2  BRESP/RRESP of last completed transaction

Behaviour:
- Clock M_AXI_ACLK; reset M_AXI_ARESET asynchronous, active-high. Reset: all VALID/READY outputs 0, addr/data outputs 0, local_ready=1, local_wdone=0, local_rdatavalid=0, local_rdata=0, local_resp=0, pending read cleared, FSM=IDLE.
- AXI byte address = {word_addr, $clog2(C_M_AXI_DATA_WIDTH/8) zeros}. AWPROT=ARPROT=3'b000; WSTRB all ones.
- FSM states: IDLE, WR (AW/W in flight), WR_B (await B), RD (AR in flight), RD_R (await R).
- IDLE: local_wen=1 -> latch addr/data, next cycle AWVALID=WVALID=1, state WR, local_ready=0. Else local_ren=1 -> latch raddr, next cycle ARVALID=1, state RD.
- Simultaneous local_wen & local_ren in IDLE: write issued first; read latched as pending, issued (ARVALID next cycle) immediately after write completes, without returning local_ready to 1 in between.
- WR: AWVALID drops the cycle after AWREADY seen; WVALID independently drops after WREADY; either order or same cycle. Both done -> WR_B with BREADY=1. VALIDs never drop before handshake; addr/data stable while VALID.
- WR_B: BVALID&BREADY -> BREADY=0, local_wdone pulse next cycle, local_resp=BRESP; -> RD if pending read else IDLE (local_ready=1 same cycle as wdone).
- RD: ARVALID until ARREADY; then RD_R with RREADY=1.
- RD_R: RVALID&RREADY -> local_rdata=RDATA, local_resp=RRESP, local_rdatavalid pulse next cycle, RREADY=0, -> IDLE.
- Minimum latency, zero-wait slave: write strobe to local_wdone = 3 cycles; read strobe to local_rdatavalid = 3 cycles.
- local_wen/local_ren while local_ready=0: ignored, no error.
- Non-OKAY responses completed normally; only reported via local_resp.
- Reset mid-transaction: immediate return to reset state; no pulses.

Optional Feature:
AXI4_LITE_MASTER_ERR_CNT_EN: adds output err_cnt [15:0]: increments once per completed B or R with resp!=2'b00, saturates at 16'hFFFF, reset 0. Without the macro, port and counter are absent; all other behaviour identical.

Test Plan:
- Write 0xDEADBEEF to word 0x05, zero-wait slave -> AWADDR=0x14, WSTRB=4'hF, local_wdone 3 cycles after wen, local_resp=0.
- Read word 0x05, slave returns 0xDEADBEEF with ARREADY delayed 4 cycles -> ARVALID held 5 cycles with ARADDR stable, local_rdatavalid once, local_rdata=0xDEADBEEF.
- WREADY 2 cycles before AWREADY, then reverse order -> each VALID drops independently, exactly one B accepted, one wdone pulse.
- wen and ren same cycle (w 0x11->0x0A, r 0x0A) -> write completes first, read returns 0x11, local_ready stays 0 until rdatavalid.
- Slave returns RRESP=2'b10 -> local_resp=2'b10, rdatavalid pulses; with AXI4_LITE_MASTER_ERR_CNT_EN, err_cnt 0->1.
- Assert M_AXI_ARESET while in RD_R -> all VALID/READY 0 and local_ready=1 immediately; subsequent write works normally.
